// File: rtl/debug_loader_pkg.sv
// ----------------------------------------------------------------------------
// debug_loader_pkg
// Purpose : shared constants for the UART debug loader: command byte codes,
//           the HALT instruction word and the controller state encodings.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package debug_loader_pkg;

   // Command bytes received over the UART
   localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
   localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
   localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

   // Writing this word ends a program load
   localparam logic [31:0] HALT_WORD = 32'h0000_003F;

   // Controller states
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_LOAD      = 4'd1;
   localparam logic [3:0] ST_WRITE     = 4'd2;
   localparam logic [3:0] ST_RUN       = 4'd3;
   localparam logic [3:0] ST_STEP      = 4'd4;
   localparam logic [3:0] ST_STEP_EXEC = 4'd5;
   localparam logic [3:0] ST_DUMP_SET  = 4'd6;
   localparam logic [3:0] ST_DUMP_SEND = 4'd7;
   localparam logic [3:0] ST_DUMP_WAIT = 4'd8;

endpackage

// File: rtl/debug_loader_if.sv
// ----------------------------------------------------------------------------
// debug_loader_if
// Purpose : bundles the UART RX/TX byte handshakes and the pipeline control /
//           debug-read signals seen by the debug loader.
// Signals : i_rx_data/i_rx_done      received byte + strobe
//           o_tx_data/o_tx_start     byte to send + start strobe
//           i_tx_done                transmitter finished previous byte
//           o_write/o_instruction    instruction-memory write pulse + word
//           o_enable                 pipeline clock-enable
//           o_debug_addr/i_data      debug read address / data (1-cycle latency)
//           i_pc, i_halt             pipeline PC and halted flag
// Modports: master = debug loader, slave = UART + pipeline side.
// ----------------------------------------------------------------------------
interface debug_loader_if #(
   parameter int INST_SZ = 32,
   parameter int REG_SZ  = 5
);
   logic [7:0]         i_rx_data;
   logic               i_rx_done;
   logic [7:0]         o_tx_data;
   logic               o_tx_start;
   logic               i_tx_done;
   logic               o_write;
   logic [INST_SZ-1:0] o_instruction;
   logic               o_enable;
   logic [REG_SZ-1:0]  o_debug_addr;
   logic [INST_SZ-1:0] i_pc;
   logic [INST_SZ-1:0] i_data;
   logic               i_halt;

   modport master (
      input  i_rx_data, i_rx_done, i_tx_done, i_pc, i_data, i_halt,
      output o_tx_data, o_tx_start, o_write, o_instruction, o_enable, o_debug_addr
   );

   modport slave (
      output i_rx_data, i_rx_done, i_tx_done, i_pc, i_data, i_halt,
      input  o_tx_data, o_tx_start, o_write, o_instruction, o_enable, o_debug_addr
   );
endinterface

// File: rtl/debug_loader_word_tx_serializer.sv
// ----------------------------------------------------------------------------
// word_tx_serializer
// Purpose : sends one word MSB first as INST_SZ/8 bytes (or only its top byte
//           when one_byte_i is set) over the UART TX start/done handshake and
//           pulses done_o once the last byte has been acknowledged.
// Ports   : i_clk, i_reset   clock, synchronous active-high reset
//           word_i, start_i  word to send, 1-cycle start strobe (ignored while busy)
//           one_byte_i       send only word_i[INST_SZ-1 -: 8]
//           tx_data_o        byte presented to the transmitter
//           tx_start_o       1-cycle strobe per byte
//           tx_done_i        transmitter finished the outstanding byte
//           done_o           1-cycle strobe after the final byte completes
// ----------------------------------------------------------------------------
module word_tx_serializer #(
   parameter int INST_SZ = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [INST_SZ-1:0] word_i,
   input  logic               start_i,
   input  logic               one_byte_i,
   output logic [7:0]         tx_data_o,
   output logic               tx_start_o,
   input  logic               tx_done_i,
   output logic               done_o
);
   localparam int NBYTES = INST_SZ / 8;
   localparam int CNT_W  = $clog2(NBYTES + 1);

   logic [INST_SZ-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]   left_q, left_d;
   logic               start_q, start_d;
   logic               out_q, out_d;     // a byte has been started and not yet acknowledged
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      sh_d    = sh_q;
      left_d  = left_q;
      start_d = 1'b0;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (!busy_q) begin
         if (start_i) begin
            sh_d    = word_i;
            left_d  = one_byte_i ? CNT_W'(1) : CNT_W'(NBYTES);
            start_d = 1'b1;
            busy_d  = 1'b1;
         end
      end else if (start_q) begin
         out_d = 1'b1;
      end else if (out_q && tx_done_i) begin
         // tx_done_i only counts while a byte is outstanding
         out_d = 1'b0;
         if (left_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            left_d  = left_q - CNT_W'(1);
            sh_d    = sh_q << 8;
            start_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sh_q    <= '0;
         left_q  <= '0;
         start_q <= 1'b0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         left_q  <= left_d;
         start_q <= start_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_data_o  = sh_q[INST_SZ-1 -: 8];
   assign tx_start_o = start_q;
   assign done_o     = done_q;

endmodule

// File: rtl/debug_loader.sv
// ----------------------------------------------------------------------------
// debug_loader
// Purpose : UART-side debug/control unit in front of the pipeline. Loads
//           program words, runs the core freely or one cycle per step, and
//           dumps PC plus NUM_DUMP debug words back over the UART.
// Ports   : i_clk, i_reset  clock, synchronous active-high reset
//           bus            debug_loader_if.master (UART + pipeline signals)
//           o_busy         1 in any state except IDLE
//           o_load_err     sticky: load hit MAX_WORDS without HALT; cleared by 'L'
// Config  : DEBUG_CHECKSUM_EN - append one byte holding the XOR of all frame
//           bytes to every dump frame.
// ----------------------------------------------------------------------------
module debug_loader
   import debug_loader_pkg::*;
#(
   parameter int INST_SZ   = 32,
   parameter int REG_SZ    = 5,
   parameter int NUM_DUMP  = 32,
   parameter int MAX_WORDS = 256
) (
   input  logic             i_clk,
   input  logic             i_reset,
   debug_loader_if.master   bus,
   output logic             o_busy,
   output logic             o_load_err
);
   localparam int WC_W = $clog2(MAX_WORDS + 1);

   logic [3:0]         state_q, state_d;
   logic [1:0]         byte_cnt_q, byte_cnt_d;   // bytes of the current word received
   logic [INST_SZ-1:0] word_q, word_d;
   logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
   logic [REG_SZ-1:0]  addr_q, addr_d;
   logic               pc_phase_q, pc_phase_d;   // dump currently sending i_pc
   logic               step_mode_q, step_mode_d; // dump was triggered by a step
   logic               load_err_q, load_err_d;

   logic               ser_start;
   logic               ser_one;
   logic               ser_done;
   logic [INST_SZ-1:0] ser_word;

`ifdef DEBUG_CHECKSUM_EN
   logic [7:0]         csum_q, csum_d;
   logic               csum_phase_q, csum_phase_d;
`endif

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_d      = word_q;
      word_cnt_d  = word_cnt_q;
      addr_d      = addr_q;
      pc_phase_d  = pc_phase_q;
      step_mode_d = step_mode_q;
      load_err_d  = load_err_q;
      ser_start   = 1'b0;
      ser_one     = 1'b0;
      ser_word    = pc_phase_q ? bus.i_pc : bus.i_data;
`ifdef DEBUG_CHECKSUM_EN
      csum_phase_d = csum_phase_q;
      csum_d       = bus.o_tx_start ? (csum_q ^ bus.o_tx_data) : csum_q;
      if (csum_phase_q) begin
         ser_word = {csum_q, {(INST_SZ-8){1'b0}}};
         ser_one  = 1'b1;
      end
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.i_rx_done) begin
               case (bus.i_rx_data)
                  CMD_LOAD: begin
                     state_d    = ST_LOAD;
                     byte_cnt_d = '0;
                     word_cnt_d = '0;
                     load_err_d = 1'b0;
                  end
                  CMD_RUN: begin
                     state_d     = ST_RUN;
                     step_mode_d = 1'b0;
                  end
                  CMD_STEP: state_d = ST_STEP;
                  default: ;
               endcase
            end
         end

         ST_LOAD: begin
            if (bus.i_rx_done) begin
               word_d     = {word_q[INST_SZ-9:0], bus.i_rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = ST_WRITE;
            end
         end

         // o_write is high for this one cycle; a byte landing here starts the next word
         ST_WRITE: begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            if (word_q == INST_SZ'(HALT_WORD)) begin
               state_d = ST_IDLE;
            end else if (word_cnt_q == WC_W'(MAX_WORDS - 1)) begin
               load_err_d = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_LOAD;
               if (bus.i_rx_done) begin
                  word_d     = {word_q[INST_SZ-9:0], bus.i_rx_data};
                  byte_cnt_d = 2'd1;
               end
            end
         end

         ST_RUN: begin
            if (bus.i_halt) begin
               state_d     = ST_DUMP_SEND;
               pc_phase_d  = 1'b1;
               addr_d      = '0;
               step_mode_d = 1'b0;
`ifdef DEBUG_CHECKSUM_EN
               csum_d       = '0;
               csum_phase_d = 1'b0;
`endif
            end
         end

         ST_STEP: begin
            if (bus.i_rx_done) begin
               if (bus.i_rx_data == CMD_NEXT) begin
                  state_d = ST_STEP_EXEC;
               end else if (bus.i_rx_data == CMD_RUN) begin
                  state_d     = ST_RUN;
                  step_mode_d = 1'b0;
               end
            end
         end

         ST_STEP_EXEC: begin
            state_d     = ST_DUMP_SEND;
            pc_phase_d  = 1'b1;
            addr_d      = '0;
            step_mode_d = 1'b1;
`ifdef DEBUG_CHECKSUM_EN
            csum_d       = '0;
            csum_phase_d = 1'b0;
`endif
         end

         // o_debug_addr changed on entry; i_data is valid from the next cycle
         ST_DUMP_SET: state_d = ST_DUMP_SEND;

         ST_DUMP_SEND: begin
            ser_start = 1'b1;
            state_d   = ST_DUMP_WAIT;
         end

         ST_DUMP_WAIT: begin
            if (ser_done) begin
               if (pc_phase_q) begin
                  pc_phase_d = 1'b0;
                  addr_d     = '0;
                  state_d    = ST_DUMP_SET;
`ifdef DEBUG_CHECKSUM_EN
               end else if (csum_phase_q) begin
                  csum_phase_d = 1'b0;
                  state_d      = (step_mode_q && !bus.i_halt) ? ST_STEP : ST_IDLE;
               end else if (addr_q == REG_SZ'(NUM_DUMP - 1)) begin
                  csum_phase_d = 1'b1;
                  state_d      = ST_DUMP_SEND;
`else
               end else if (addr_q == REG_SZ'(NUM_DUMP - 1)) begin
                  state_d = (step_mode_q && !bus.i_halt) ? ST_STEP : ST_IDLE;
`endif
               end else begin
                  addr_d  = addr_q + REG_SZ'(1);
                  state_d = ST_DUMP_SET;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= '0;
         word_q      <= '0;
         word_cnt_q  <= '0;
         addr_q      <= '0;
         pc_phase_q  <= 1'b0;
         step_mode_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_q      <= word_d;
         word_cnt_q  <= word_cnt_d;
         addr_q      <= addr_d;
         pc_phase_q  <= pc_phase_d;
         step_mode_q <= step_mode_d;
         load_err_q  <= load_err_d;
      end
   end

`ifdef DEBUG_CHECKSUM_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         csum_q       <= '0;
         csum_phase_q <= 1'b0;
      end else begin
         csum_q       <= csum_d;
         csum_phase_q <= csum_phase_d;
      end
   end
`endif

   word_tx_serializer #(.INST_SZ(INST_SZ)) u_ser (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .word_i     (ser_word),
      .start_i    (ser_start),
      .one_byte_i (ser_one),
      .tx_data_o  (bus.o_tx_data),
      .tx_start_o (bus.o_tx_start),
      .tx_done_i  (bus.i_tx_done),
      .done_o     (ser_done)
   );

   // Enable drops combinationally in the cycle i_halt is seen
   assign bus.o_enable      = ((state_q == ST_RUN) && !bus.i_halt) || (state_q == ST_STEP_EXEC);
   assign bus.o_write       = (state_q == ST_WRITE);
   assign bus.o_instruction = word_q;
   assign bus.o_debug_addr  = addr_q;
   assign o_busy            = (state_q != ST_IDLE);
   assign o_load_err        = load_err_q;

endmodule
